// File: rtl/s526_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : s526_ctrl_pkg
// Brief  : Shared types and constants for the s526 step sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package s526_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_WAIT_VEC = 3'd2,
        ST_APPLY    = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [15:0] C_MISR_POLY = 16'h1021;
    localparam logic [15:0] C_MISR_SEED = 16'hFFFF;

    // Core input bit positions (G0/G1/G2)
    localparam int C_DIN_G0 = 0;
    localparam int C_DIN_G1 = 1;
    localparam int C_DIN_G2 = 2;

    // Core output bit positions
    localparam int C_DOUT_G147 = 0;
    localparam int C_DOUT_G148 = 1;
    localparam int C_DOUT_G198 = 2;
    localparam int C_DOUT_G199 = 3;
    localparam int C_DOUT_G213 = 4;
    localparam int C_DOUT_G214 = 5;

    // Flush vector: G0 high, others low
    localparam logic [2:0] C_INIT_VEC = 3'b001;

endpackage
`default_nettype wire

// File: rtl/s526_misr.sv
`default_nettype none
// ============================================================================
// Module : s526_misr
// Brief  : 16-bit multiple-input signature register folding in a 6-bit word.
// Rev    : 1.0  initial release
// ============================================================================
module s526_misr #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [5:0]  i_din,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? POLY : 16'h0000) ^ {10'b0, i_din};
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/s526_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : s526_seq_ctrl
// Brief  : Flushes the s526 core, steps it once per host vector and returns
//          each post-step output through a one-entry result buffer + MISR.
// Rev    : 1.0  initial release
// ============================================================================
module s526_seq_ctrl
    import s526_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int          INIT_CYCLES = 4,
    parameter logic [15:0] MISR_POLY   = C_MISR_POLY,
    parameter logic [15:0] MISR_SEED   = C_MISR_SEED
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             vec_valid,
    input  logic [2:0]       vec_data,
    output logic             vec_ready,
    output logic [2:0]       dut_in,
    output logic             dut_ce,
    input  logic [5:0]       dut_out,
    output logic             res_valid,
    output logic [5:0]       res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature
);

    localparam int                ICNT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICNT_W-1:0] C_ICNT_LOAD = ICNT_W'((INIT_CYCLES > 0) ? (INIT_CYCLES - 1) : 0);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_rem;
    logic [ICNT_W-1:0]  r_icnt;
    logic [2:0]         r_vec;
    logic               r_res_valid;
    logic [5:0]         r_res_data;
    logic               r_busy;
    logic               r_done;

    logic               w_start;
    logic               w_load_res;
    logic               w_abort;
    logic [2:0]         w_dut_in;
    logic               w_dut_ce;
    logic               w_vec_ready;
    logic [2:0]         w_vec_in;
    logic [5:0]         w_capt;

    assign w_vec_in = {vec_data[C_DIN_G2], vec_data[C_DIN_G1], vec_data[C_DIN_G0]};
    assign w_capt   = {dut_out[C_DOUT_G214], dut_out[C_DOUT_G213], dut_out[C_DOUT_G199],
                       dut_out[C_DOUT_G198], dut_out[C_DOUT_G148], dut_out[C_DOUT_G147]};

    // abort wins over start even in IDLE; alone in IDLE it does nothing
    assign w_abort = abort && (r_state != ST_IDLE);
    assign w_start = (r_state == ST_IDLE) && start && !abort;

    always_comb begin
        w_next      = r_state;
        w_load_res  = 1'b0;
        w_dut_in    = 3'b000;
        w_dut_ce    = 1'b0;
        w_vec_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (num_steps == '0)
                        w_next = ST_DONE;
                    else if (INIT_CYCLES == 0)
                        w_next = ST_WAIT_VEC;
                    else
                        w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_dut_in = C_INIT_VEC;
                w_dut_ce = 1'b1;
                if (r_icnt == '0)
                    w_next = ST_WAIT_VEC;
            end
            ST_WAIT_VEC: begin
                w_vec_ready = 1'b1;
                if (vec_valid)
                    w_next = ST_APPLY;
            end
            ST_APPLY: begin
                w_dut_in = r_vec;
                w_dut_ce = 1'b1;
                w_next   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!r_res_valid || res_ready) begin
                    w_load_res = 1'b1;
                    w_next     = (r_rem == CNT_W'(1)) ? ST_DONE : ST_WAIT_VEC;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next     = ST_IDLE;
            w_load_res = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_icnt      <= '0;
            r_vec       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);

            if (w_start) begin
                r_rem  <= num_steps;
                r_icnt <= C_ICNT_LOAD;
            end else if (r_state == ST_INIT && r_icnt != '0) begin
                r_icnt <= r_icnt - ICNT_W'(1);
            end

            if (r_state == ST_WAIT_VEC && vec_valid)
                r_vec <= w_vec_in;

            if (w_load_res) begin
                r_res_data <= w_capt;
                r_rem      <= r_rem - CNT_W'(1);
            end

            // a drain and a reload in the same cycle keep the entry valid
            if (w_abort)
                r_res_valid <= 1'b0;
            else if (w_load_res)
                r_res_valid <= 1'b1;
            else if (r_res_valid && res_ready)
                r_res_valid <= 1'b0;
        end
    end

    s526_misr #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk    (CK),
        .rst_n  (RN),
        .i_load (w_start),
        .i_en   (w_load_res),
        .i_din  (w_capt),
        .o_sig  (signature)
    );

    assign vec_ready = w_vec_ready;
    assign dut_in    = w_dut_in;
    assign dut_ce    = w_dut_ce;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_s526_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_s526_seq_ctrl
// Brief  : Scoreboard bench for s526_seq_ctrl with a stand-in stepping core.
// Rev    : 1.0  initial release
// ============================================================================
module tb_s526_seq_ctrl;

    localparam int INIT_CYCLES = 4;

    typedef logic [2:0] vq_t[$];

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_steps = '0;
    logic        vec_valid = 1'b0;
    logic [2:0]  vec_data = '0;
    logic        res_ready = 1'b0;
    wire         vec_ready;
    wire  [2:0]  dut_in;
    wire         dut_ce;
    wire  [5:0]  dut_out;
    wire         res_valid;
    wire  [5:0]  res_data;
    wire         busy;
    wire         done;
    wire  [15:0] signature;

    s526_seq_ctrl #(
        .CNT_W       (16),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .start     (start),
        .abort     (abort),
        .num_steps (num_steps),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .dut_in    (dut_in),
        .dut_ce    (dut_ce),
        .dut_out   (dut_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    always #5 CK = ~CK;

    // Stand-in core: arbitrary 6-bit state machine, outputs depend on state only
    function automatic logic [5:0] core_f(input logic [5:0] s, input logic [2:0] v);
        int t;
        t = (int'(s) * 5 + int'(v) * 9 + 3) % 64;
        return 6'(t);
    endfunction

    // Signature = running polynomial remainder with each word XORed in
    function automatic logic [15:0] misr_f(input logic [15:0] s, input logic [5:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0] ^ {10'b0, d};
    endfunction

    logic [5:0] core_st = 6'h2A;
    logic       force_en = 1'b0;
    logic [5:0] force_val = '0;

    always @(posedge CK) if (dut_ce) core_st <= core_f(core_st, dut_in);
    assign dut_out = force_en ? force_val : core_st;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [5:0]  exp_res[$];
    logic [15:0] exp_sig[$];
    logic [2:0]  vq[$];
    int          ce_cyc[$];
    logic [2:0]  ce_in[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          rr_mode = 0;
    bit          gap_en = 1'b0;

    always @(posedge CK) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a result or done
    always @(negedge CK) begin
        if (RN) begin
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none", res_data);
                end else begin
                    chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_sig.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got signature %0h expected none", signature);
                end else begin
                    chk("signature", 32'(signature), 32'(exp_sig.pop_front()));
                end
            end
            if (dut_ce) begin
                ce_cyc.push_back(cyc);
                ce_in.push_back(dut_in);
            end
        end
    end

    initial begin
        forever begin
            @(posedge CK);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Vector source: holds each vector stable until accepted
    initial begin
        bit acc;
        forever begin
            @(negedge CK);
            acc = vec_valid && vec_ready;
            @(posedge CK);
            #1;
            if (acc) begin
                void'(vq.pop_front());
                vec_valid = 1'b0;
            end
            if (!vec_valid && vq.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                vec_valid = 1'b1;
                vec_data  = vq[0];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run_begin(input int n, input vq_t vs, input bit expect_res);
        logic [5:0]  s;
        logic [5:0]  o;
        logic [15:0] sig;
        if (expect_res) begin
            s   = core_st;
            sig = 16'hFFFF;
            if (n != 0) begin
                repeat (INIT_CYCLES) s = core_f(s, 3'b001);
                foreach (vs[i]) begin
                    s = core_f(s, vs[i]);
                    o = force_en ? force_val : s;
                    exp_res.push_back(o);
                    sig = misr_f(sig, o);
                end
            end
            exp_sig.push_back(sig);
        end
        foreach (vs[i]) vq.push_back(vs[i]);
        ce_cyc.delete();
        ce_in.delete();
        done_base = done_cnt;
        start     = 1'b1;
        num_steps = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run_end(input int bound);
        int k;
        k = 0;
        while (done_cnt == done_base && k < bound) begin
            tick();
            k++;
        end
        chk("done_pulses", 32'(done_cnt - done_base), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        k = 0;
        while (exp_res.size() > 0 && k < bound) begin
            tick();
            k++;
        end
        chk("results_drained", 32'(exp_res.size()), 32'd0);
    endtask

    task automatic chk_flush(input string tag);
        chk({tag, "_ce_count"}, 32'(ce_cyc.size()), 32'(INIT_CYCLES + 2));
        if (ce_cyc.size() == INIT_CYCLES + 2) begin
            for (int i = 0; i < INIT_CYCLES; i++)
                chk({tag, "_flush_vec"}, 32'(ce_in[i]), 32'd1);
            chk({tag, "_flush_contig"}, 32'(ce_cyc[INIT_CYCLES-1] - ce_cyc[0]), 32'(INIT_CYCLES - 1));
        end
    endtask

    initial begin
        vq_t         v;
        int          k;
        int          d0;
        logic [15:0] sig_hold;

        repeat (3) @(posedge CK);
        #1;
        chk("rst_vec_ready", 32'(vec_ready), 32'd0);
        chk("rst_dut_in",    32'(dut_in),    32'd0);
        chk("rst_dut_ce",    32'(dut_ce),    32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_signature", 32'(signature), 32'd0);
        RN = 1'b1;
        tick();

        // Reset in the middle of the flush
        v = {};
        run_begin(2, v, 1'b0);
        chk("init_ce", 32'(dut_ce), 32'd1);
        tick();
        RN = 1'b0;
        #1;
        chk("midrst_dut_ce", 32'(dut_ce), 32'd0);
        chk("midrst_dut_in", 32'(dut_in), 32'd0);
        chk("midrst_busy",   32'(busy),   32'd0);
        tick();
        RN = 1'b1;
        tick();
        chk("midrst_idle", 32'(busy), 32'd0);

        // Directed two-vector run
        rr_mode = 0;
        gap_en  = 1'b0;
        v = {3'b000, 3'b100};
        run_begin(2, v, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        run_end(100);
        chk_flush("dir");
        if (ce_cyc.size() == INIT_CYCLES + 2) begin
            chk("dir_vec0", 32'(ce_in[INIT_CYCLES]),   32'h0);
            chk("dir_vec1", 32'(ce_in[INIT_CYCLES+1]), 32'h4);
            chk("dir_throughput", 32'(ce_cyc[INIT_CYCLES+1] - ce_cyc[INIT_CYCLES]), 32'd3);
        end

        // Signature with forced core outputs
        force_en  = 1'b1;
        force_val = 6'h00;
        v = {3'b010};
        run_begin(1, v, 1'b1);
        run_end(100);
        chk("misr_00", 32'(signature), 32'hEFDF);
        force_val = 6'h3F;
        run_begin(1, v, 1'b1);
        run_end(100);
        chk("misr_3f", 32'(signature), 32'hEFE0);
        force_en = 1'b0;

        // Backpressure: result sink stalled
        rr_mode = 2;
        tick();
        tick();
        v = {3'b001, 3'b011, 3'b110};
        run_begin(3, v, 1'b1);
        repeat (INIT_CYCLES + 12) tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CK);
            chk("bp_dut_ce",    32'(dut_ce),    32'd0);
            chk("bp_vec_ready", 32'(vec_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
        end
        chk("bp_vec_left", 32'(vq.size()), 32'd1);
        rr_mode = 0;
        tick();
        run_end(100);

        // Zero-length run
        v = {};
        run_begin(0, v, 1'b1);
        @(negedge CK);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_sig",  32'(signature), 32'hFFFF);
        run_end(20);
        chk("zero_no_ce", 32'(ce_cyc.size()), 32'd0);

        // abort and start together in IDLE: start is suppressed
        abort = 1'b1;
        start = 1'b1;
        num_steps = 16'd2;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle", 32'(busy), 32'd0);

        // abort in WAIT_VEC with an unconsumed result pending
        rr_mode = 2;
        tick();
        v = {3'b101};
        run_begin(3, v, 1'b0);
        k = 0;
        while (!(res_valid && vec_ready) && k < 40) begin
            tick();
            k++;
        end
        chk("abort_reach_wait", 32'(res_valid && vec_ready), 32'd1);
        sig_hold = signature;
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_dut_ce",    32'(dut_ce),    32'd0);
        chk("abort_sig_held",  32'(signature), 32'(sig_hold));
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        rr_mode = 0;
        tick();
        v = {3'b011, 3'b000};
        run_begin(2, v, 1'b1);
        run_end(100);
        chk_flush("post_abort");

        // Randomised runs
        rr_mode = 1;
        gap_en  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            v = {};
            for (int i = 0; i < n; i++) v.push_back(3'($urandom_range(0, 7)));
            run_begin(n, v, 1'b1);
            run_end(400);
        end

        chk("sig_queue_empty", 32'(exp_sig.size()), 32'd0);
        chk("vec_queue_empty", 32'(vq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
